// File: rtl/core_reset_seq.sv
// Reset / ROM-download sequencer: holds the game core in reset until every required index has loaded, then releases after HOLD_CYCLES.
// Optional download watchdog (stalled-write abort) is enabled by defining RESET_SEQ_WDOG_EN.
module core_reset_seq #(
   parameter int                 NUM_IDX     = 4,
   parameter logic [NUM_IDX-1:0] REQ_MASK    = NUM_IDX'(1),
   parameter int                 HOLD_CYCLES = 1024,
   parameter int                 WDOG_CYCLES = 65536
) (
   input  logic               i_clk_sys,
   input  logic               i_reset,
   input  logic               i_ioctl_downl,
   input  logic [7:0]         i_ioctl_index,
   input  logic               i_ioctl_wr,
   input  logic               i_user_reset,
   output logic               o_core_reset,
   output logic [NUM_IDX-1:0] o_rom_download,
   output logic [NUM_IDX-1:0] o_loaded,
   output logic               o_all_loaded,
   output logic               o_dl_error
);

   localparam int HW = $clog2(HOLD_CYCLES + 1);
   localparam logic [HW-1:0] HOLD_LOAD = HW'(HOLD_CYCLES - 1);

   if (NUM_IDX < 1 || NUM_IDX > 8 || HOLD_CYCLES < 1 || WDOG_CYCLES < 2) begin : g_param_err
      $error("core_reset_seq: illegal parameter value");
   end

   typedef enum logic [2:0] {
      S_WAIT_ROM,
      S_DOWNLOAD,
      S_HOLD,
      S_RUN
`ifdef RESET_SEQ_WDOG_EN
      , S_ABORT
`endif
   } state_t;

   state_t             r_state;
   logic [7:0]         r_idx;
   logic               r_wr_seen;
   logic [NUM_IDX-1:0] r_loaded;
   logic               r_core_reset;
   logic [HW-1:0]      r_hold_cnt;

   logic [NUM_IDX-1:0] w_rom_download;
   logic [NUM_IDX-1:0] w_idx_hot;
   logic [NUM_IDX-1:0] w_loaded_done;
   logic               w_done_all;
   logic               w_all_loaded;
   logic               w_start_dl;

`ifdef RESET_SEQ_WDOG_EN
   localparam int WW = $clog2(WDOG_CYCLES + 1);
   localparam logic [WW-1:0] WDOG_LAST = WW'(WDOG_CYCLES - 1);
   logic [WW-1:0] r_idle_cnt;
   logic          r_dl_error;
   assign o_dl_error = r_dl_error;
   // A download already aborted stays in ABORT until ioctl_downl drops.
   assign w_start_dl = i_ioctl_downl && (r_state != S_DOWNLOAD) && (r_state != S_ABORT);
`else
   assign o_dl_error = 1'b0;
   assign w_start_dl = i_ioctl_downl && (r_state != S_DOWNLOAD);
`endif

   always_comb begin
      w_rom_download = '0;
      w_idx_hot      = '0;
      for (int i = 0; i < NUM_IDX; i++) begin
         w_rom_download[i] = i_ioctl_downl && (i_ioctl_index == 8'(i));
         w_idx_hot[i]      = (r_idx == 8'(i));
      end
   end

   // Indices >= NUM_IDX have no hot bit, so they never set a flag.
   assign w_loaded_done = r_wr_seen ? (r_loaded | w_idx_hot) : r_loaded;
   assign w_done_all    = (w_loaded_done & REQ_MASK) == REQ_MASK;
   assign w_all_loaded  = (r_loaded & REQ_MASK) == REQ_MASK;

   assign o_rom_download = w_rom_download;
   assign o_loaded       = r_loaded;
   assign o_all_loaded   = w_all_loaded;
   assign o_core_reset   = r_core_reset;

   always_ff @(posedge i_clk_sys or posedge i_reset) begin
      if (i_reset) begin
         r_state      <= S_WAIT_ROM;
         r_idx        <= '0;
         r_wr_seen    <= 1'b0;
         r_loaded     <= '0;
         r_core_reset <= 1'b1;
         r_hold_cnt   <= '0;
`ifdef RESET_SEQ_WDOG_EN
         r_idle_cnt   <= '0;
         r_dl_error   <= 1'b0;
`endif
      end else if (w_start_dl) begin
         r_state      <= S_DOWNLOAD;
         r_idx        <= i_ioctl_index;
         r_wr_seen    <= 1'b0;
         r_loaded     <= r_loaded & ~w_rom_download;
         r_core_reset <= 1'b1;
`ifdef RESET_SEQ_WDOG_EN
         r_idle_cnt   <= '0;
         r_dl_error   <= 1'b0;
`endif
      end else begin
         case (r_state)
            S_DOWNLOAD: begin
               if (!i_ioctl_downl) begin
                  r_loaded <= w_loaded_done;
                  if (w_done_all) begin
                     r_state    <= S_HOLD;
                     r_hold_cnt <= HOLD_LOAD;
                  end else begin
                     r_state <= S_WAIT_ROM;
                  end
               end else if (i_ioctl_wr) begin
                  r_wr_seen <= 1'b1;
`ifdef RESET_SEQ_WDOG_EN
                  r_idle_cnt <= '0;
               end else if (r_idle_cnt == WDOG_LAST) begin
                  r_dl_error <= 1'b1;
                  r_state    <= S_ABORT;
               end else begin
                  r_idle_cnt <= r_idle_cnt + 1'b1;
`endif
               end
            end
`ifdef RESET_SEQ_WDOG_EN
            S_ABORT: begin
               if (!i_ioctl_downl) begin
                  if (w_all_loaded) begin
                     r_state    <= S_HOLD;
                     r_hold_cnt <= HOLD_LOAD;
                  end else begin
                     r_state <= S_WAIT_ROM;
                  end
               end
            end
`endif
            S_HOLD: begin
               if (i_user_reset) begin
                  r_hold_cnt <= HOLD_LOAD;
               end else if (r_hold_cnt == '0) begin
                  r_state      <= S_RUN;
                  r_core_reset <= 1'b0;
               end else begin
                  r_hold_cnt <= r_hold_cnt - 1'b1;
               end
            end
            S_RUN: begin
               if (i_user_reset) begin
                  r_state      <= S_HOLD;
                  r_hold_cnt   <= HOLD_LOAD;
                  r_core_reset <= 1'b1;
               end
            end
            default: begin
               r_state      <= S_WAIT_ROM;
               r_core_reset <= 1'b1;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_core_reset_seq.sv
// Directed bench for core_reset_seq: two instances (REQ_MASK 0001 and 0011) driven by the same download/user-reset stimulus.
module tb_core_reset_seq;

   logic       clk = 1'b0;
   logic       rst, downl, wr, ureset;
   logic [7:0] idx;
   logic       cr1, cr2, ae1, ae2, de1, de2;
   logic [3:0] rd1, rd2, ld1, ld2;
   int         checks = 0;
   int         failures = 0;
`ifdef RESET_SEQ_WDOG_EN
   localparam bit WD = 1'b1;
`else
   localparam bit WD = 1'b0;
`endif

   always #5 clk = ~clk;

   core_reset_seq #(.NUM_IDX(4), .REQ_MASK(4'b0001), .HOLD_CYCLES(16), .WDOG_CYCLES(32)) u_dut1 (
      .i_clk_sys(clk), .i_reset(rst), .i_ioctl_downl(downl), .i_ioctl_index(idx), .i_ioctl_wr(wr),
      .i_user_reset(ureset), .o_core_reset(cr1), .o_rom_download(rd1), .o_loaded(ld1),
      .o_all_loaded(ae1), .o_dl_error(de1));

   core_reset_seq #(.NUM_IDX(4), .REQ_MASK(4'b0011), .HOLD_CYCLES(16), .WDOG_CYCLES(32)) u_dut2 (
      .i_clk_sys(clk), .i_reset(rst), .i_ioctl_downl(downl), .i_ioctl_index(idx), .i_ioctl_wr(wr),
      .i_user_reset(ureset), .o_core_reset(cr2), .o_rom_download(rd2), .o_loaded(ld2),
      .o_all_loaded(ae2), .o_dl_error(de2));

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         failures++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   task automatic tick(input int n);
      repeat (n) begin
         @(posedge clk);
         #1;
      end
   endtask

   // Entry edge, nwr write strobes, then gap idle cycles; ioctl_downl is left high.
   task automatic download(input logic [7:0] id, input int nwr, input int gap);
      downl = 1'b1;
      idx   = id;
      wr    = 1'b0;
      tick(1);
      wr = 1'b1;
      tick(nwr);
      wr = 1'b0;
      tick(gap);
   endtask

   initial begin
      rst = 1'b1; downl = 1'b0; wr = 1'b0; ureset = 1'b0; idx = 8'd0;
      tick(2);
      check("rst_core_reset", cr1, 1);
      check("rst_loaded", ld1, 4'b0000);
      check("rst_dl_error", de1, 0);
      check("rst_rom_download", rd1, 4'b0000);
      check("rst_all_loaded", ae1, 0);
      rst = 1'b0;
      tick(2);

      // Index 0, 100 writes: mask 0001 releases 16 edges after completion.
      downl = 1'b1; idx = 8'd0; #1;
      check("rom_download_idx0", rd1, 4'b0001);
      download(8'd0, 100, 2);
      downl = 1'b0;
      tick(1);
      check("a_loaded", ld1, 4'b0001);
      check("a_all_loaded", ae1, 1);
      check("a_core_reset_E", cr1, 1);
      check("a_dut2_all_loaded", ae2, 0);
      tick(15);
      check("a_core_reset_E15", cr1, 1);
      tick(1);
      check("a_core_reset_E16", cr1, 0);
      check("a_dut2_core_reset", cr2, 1);
      tick(5);
      check("a_dut2_still_wait", cr2, 1);

      // Index 1 download from RUN: 1-cycle reset latency; mask 0011 completes.
      downl = 1'b1; idx = 8'd1; #1;
      check("b_core_reset_before_edge", cr1, 0);
      tick(1);
      check("b_core_reset_after_edge", cr1, 1);
      wr = 1'b1; tick(10); wr = 1'b0;
      downl = 1'b0;
      tick(1);
      check("b_dut2_loaded", ld2, 4'b0011);
      check("b_dut2_all_loaded", ae2, 1);
      tick(15);
      check("b_dut2_core_reset_E15", cr2, 1);
      tick(1);
      check("b_dut2_core_reset_E16", cr2, 0);
      check("b_dut1_core_reset_E16", cr1, 0);

      // User reset pulse of 5 cycles while running.
      ureset = 1'b1;
      tick(1);
      check("c_core_reset_rise", cr1, 1);
      tick(4);
      ureset = 1'b0;
      tick(15);
      check("c_core_reset_15", cr1, 1);
      tick(1);
      check("c_core_reset_16", cr1, 0);

      // Zero-write download of index 0 leaves its flag clear.
      downl = 1'b1; idx = 8'd0;
      tick(5);
      downl = 1'b0;
      tick(1);
      check("d_loaded", ld1, 4'b0010);
      check("d_all_loaded", ae1, 0);
      tick(20);
      check("d_core_reset_wait", cr1, 1);

      // Async reset mid-HOLD (counter = 8).
      download(8'd0, 5, 0);
      downl = 1'b0;
      tick(1);
      check("e_loaded_hold", ld1, 4'b0011);
      tick(7);
      #2 rst = 1'b1;
      #1;
      check("e_async_core_reset", cr1, 1);
      check("e_async_loaded", ld1, 4'b0000);
      check("e_async_dut2_loaded", ld2, 4'b0000);
      downl = 1'b1; idx = 8'd2; #1;
      check("e_rom_download_idx2", rd1, 4'b0100);
      idx = 8'd9; #1;
      check("e_rom_download_untracked", rd1, 4'b0000);
      downl = 1'b0; #1;
      check("e_rom_download_off", rd1, 4'b0000);
      tick(1);
      rst = 1'b0;
      tick(2);

      // Index 0 with a 40-cycle write gap.
      downl = 1'b1; idx = 8'd0;
      tick(1);
      wr = 1'b1; tick(3); wr = 1'b0;
      tick(31);
      check("f_dl_error_idle31", de1, 0);
      tick(1);
      check("f_dl_error_idle32", de1, WD ? 1 : 0);
      tick(8);
      wr = 1'b1; tick(3); wr = 1'b0;
      downl = 1'b0;
      tick(1);
      check("f_loaded", ld1, WD ? 4'b0000 : 4'b0001);
      check("f_dl_error_after", de1, WD ? 1 : 0);
      tick(15);
      check("f_core_reset_15", cr1, 1);
      tick(1);
      check("f_core_reset_16", cr1, WD ? 1 : 0);

      // A fresh download clears dl_error.
      downl = 1'b1; idx = 8'd3;
      tick(1);
      check("g_dl_error_cleared", de1, 0);
      wr = 1'b1; tick(2); wr = 1'b0;
      downl = 1'b0;
      tick(1);
      check("g_loaded", ld1, WD ? 4'b1000 : 4'b1001);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule

// File: doc/core_reset_seq.md
# core_reset_seq

Parametrised reset and ROM-download sequencer for MiST arcade cores, sitting between `data_io`/`user_io` and the game core. It tracks up to NUM_IDX download indices separately and holds the core in reset until every required index has loaded completely. Release is delayed by a programmable hold count. The user/OSD reset gets the same sequencing, and an optional watchdog detects stalled downloads.

## Interface
- NUM_IDX, 4: number of tracked `ioctl_index` values (0..NUM_IDX-1), 1..8
- REQ_MASK, 4'b0001: indices that must be loaded before reset release; width NUM_IDX
- HOLD_CYCLES, 1024: reset hold after all conditions are met, ≥1
- WDOG_CYCLES, 65536: idle-write limit during a download, ≥2; only used with watchdog
- clk_sys  in  1  system clock (clk_72 in current cores)
- reset  in  1  asynchronous, active-high (typically ~pll_locked)
- ioctl_downl  in  1  download active, from `data_io`
- ioctl_index  in  8  download index, stable while ioctl_downl=1
- ioctl_wr  in  1  download write strobe
- user_reset  in  1  status[0] | buttons[1]; level
- core_reset  out  1  registered, reset to the game core
- rom_download  out  NUM_IDX  per-index download-active decode
- loaded  out  NUM_IDX  per-index "completed download" flags
- all_loaded  out  1  (loaded & REQ_MASK) == REQ_MASK
- dl_error  out  1  last download aborted by watchdog

## Operation
- Reset values: core_reset=1, loaded=0, dl_error=0, state WAIT_ROM, counters 0. rom_download=0 because ioctl_downl is low.
- rom_download[i] = ioctl_downl & (ioctl_index==i). Combinational, zero latency. Indices ≥ NUM_IDX decode to all zeros.
- States are WAIT_ROM, DOWNLOAD, HOLD, RUN and ABORT (ABORT exists only with the watchdog).
- Any state with ioctl_downl=1 goes to DOWNLOAD. This applies to untracked indices too.
- On DOWNLOAD entry:
  - Capture the index.
  - Clear wr_seen.
  - Clear loaded[idx] if idx < NUM_IDX.
  - Clear dl_error.
- Inside DOWNLOAD, ioctl_wr sets wr_seen.
- When ioctl_downl=0 in DOWNLOAD:
  - Set loaded[idx] if idx < NUM_IDX and wr_seen=1. A zero-write download leaves the flag at 0.
  - Then evaluate: if all_loaded (using the updated flags), go to HOLD; otherwise go to WAIT_ROM.
- WAIT_ROM: core_reset=1. Leaves only through DOWNLOAD.
- HOLD: core_reset=1.
  - Counter loads HOLD_CYCLES-1 on entry.
  - Counter reloads every cycle user_reset=1.
  - Otherwise it decrements.
  - At 0 with user_reset=0, go to RUN.
- RUN: core_reset=0. user_reset=1 goes to HOLD.
- Priority when events coincide: ioctl_downl > user_reset > counter expiry.
- Asserting reset at any time returns everything to reset values immediately. loaded is lost, so ROMs must be re-downloaded.

## Timing
- core_reset rises on the first clk_sys edge that samples ioctl_downl=1 in RUN or HOLD: 1-cycle latency.
- core_reset rises on the first edge sampling user_reset=1 in RUN: 1-cycle latency.
- With HOLD entered at edge E0 and user_reset=0 throughout, core_reset falls at edge E0+HOLD_CYCLES.
- loaded/all_loaded update on the edge that samples ioctl_downl=0 in DOWNLOAD, which is also the edge that enters HOLD.
- The loaded and dl_error outputs change only on clk_sys edges. rom_download is combinational and all_loaded is derived from loaded.

## Configuration
- RESET_SEQ_WDOG_EN defined:
  - In DOWNLOAD, an idle counter is cleared on entry and on each ioctl_wr, and increments otherwise.
  - When it reaches WDOG_CYCLES, set dl_error=1 and enter ABORT.
  - ABORT holds core_reset=1 until ioctl_downl=0. It then leaves loaded[idx]=0 and goes to WAIT_ROM, or to HOLD if all_loaded still holds (e.g. untracked idx).
  - A new download clears dl_error.
- RESET_SEQ_WDOG_EN undefined:
  - No idle counter and no ABORT state.
  - dl_error is tied to 0.
  - WDOG_CYCLES is ignored.

## Test plan
- Power-up, NUM_IDX=4, REQ_MASK=0001, HOLD_CYCLES=16:
  - Stimulus: download index 0 with 100 writes. ioctl_downl falls at edge E.
  - Expect loaded=0001 at E, all_loaded=1, core_reset=0 at E+16.
- REQ_MASK=0011:
  - Stimulus: load index 0 only.
  - Expect core_reset stays 1 and state WAIT_ROM. After also loading index 1, release 16 cycles later.
- In RUN:
  - Stimulus: pulse user_reset for 5 cycles.
  - Expect core_reset=1 one edge after rise and 0 exactly 16 edges after user_reset returns low.
  - Stimulus: download index 0 with 0 writes.
  - Expect loaded[0]=0 and core_reset stays 1.
- Mid-HOLD (counter=8):
  - Stimulus: assert reset asynchronously.
  - Expect core_reset=1 and loaded=0 without a clock edge. rom_download follows ioctl_downl throughout.
- With RESET_SEQ_WDOG_EN, WDOG_CYCLES=32:
  - Stimulus: ioctl_downl=1 for index 0 with a 40-cycle write gap.
  - Expect dl_error=1 at idle count 32, loaded[0]=0 after downl falls, then WAIT_ROM.
  - Without the macro, the same stimulus gives loaded[0]=1 and dl_error=0.
